// File: rtl/stats_pkg.sv
// stats_pkg: shared constants, types and the frame word mux
// for the stats readout (counter + snapshot streamer).
package stats_pkg;

  localparam int FRAME_WORDS = 12;
  localparam int IDX_W = 4;

  localparam logic [15:0] HEADER_DEFAULT = 16'hA55A;

  typedef logic [IDX_W-1:0] idx_t;

  // First word index of each frame field.
  localparam idx_t IDX_CNT  = 4'd1;
  localparam idx_t IDX_SUM  = 4'd3;
  localparam idx_t IDX_SQ   = 4'd7;
  localparam idx_t IDX_CSUM = 4'd11;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  typedef struct packed {
    logic [31:0] cnt;
    logic [63:0] sum;
    logic [63:0] sq;
  } snap_t;

  // Word at index idx; fields are sent MS word first.
  function automatic logic [15:0] frame_word(
    input logic [15:0] hdr,
    input snap_t       s,
    input idx_t        idx,
    input logic [15:0] csum
  );
    logic [15:0] w;
    w = '0;
    unique case (idx)
      4'd0:         w = hdr;
      IDX_CNT:      w = s.cnt[31:16];
      IDX_CNT + 1:  w = s.cnt[15:0];
      IDX_SUM:      w = s.sum[63:48];
      IDX_SUM + 1:  w = s.sum[47:32];
      IDX_SUM + 2:  w = s.sum[31:16];
      IDX_SUM + 3:  w = s.sum[15:0];
      IDX_SQ:       w = s.sq[63:48];
      IDX_SQ + 1:   w = s.sq[47:32];
      IDX_SQ + 2:   w = s.sq[31:16];
      IDX_SQ + 3:   w = s.sq[15:0];
      IDX_CSUM:     w = csum;
      default:      w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/stats_sample_counter.sv
// stats_sample_counter: saturating sample counter kept in
// lock-step with the sum / sum-of-squares accumulator.
// Ports: clk_i, rst_i (async, active high), mode_i (0 = clear),
//        status_i (0 = sample present), count_o (W bits).
module stats_sample_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mode_i,
  input  logic         status_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!mode_i) begin
      cnt_d = '0;
    end else if (!status_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/stats_readout.sv
// stats_readout: snapshots count / sum / sum-of-squares on
// capture and streams a 12-word frame with trailing checksum.
// Ports: clk, reset (async, active high), mode, status,
//        sum_in, sum_square_in, capture, busy,
//        out_data / out_valid / out_ready / out_last (stream).
module stats_readout
  import stats_pkg::*;
#(
  parameter logic [15:0] HEADER = HEADER_DEFAULT,
  parameter int          CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode,
  input  logic        status,
  input  logic [63:0] sum_in,
  input  logic [63:0] sum_square_in,
  input  logic        capture,
  output logic        busy,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  state_t      state_q;
  state_t      state_d;
  idx_t        idx_q;
  idx_t        idx_d;
  logic [15:0] csum_q;
  logic [15:0] csum_d;
  snap_t       snap_q;
  snap_t       snap_d;

  logic [CNT_W-1:0] count;
  logic [15:0]      word;

  stats_sample_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i    (clk),
    .rst_i    (reset),
    .mode_i   (mode),
    .status_i (status),
    .count_o  (count)
  );

  // Word is a pure function of registered state, so out_data
  // never sees out_ready combinationally.
  assign word = frame_word(HEADER, snap_q, idx_q, csum_q);

  assign busy      = (state_q == SEND);
  assign out_valid = busy;
  assign out_last  = busy & (idx_q == IDX_CSUM);
  assign out_data  = busy ? word : 16'h0000;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    snap_d  = snap_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          snap_d.cnt = count;
          snap_d.sum = sum_in;
          snap_d.sq  = sum_square_in;
          idx_d      = '0;
          csum_d     = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == IDX_CSUM) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            csum_d = csum_q + word;
            idx_d  = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      snap_q  <= snap_d;
    end
  end

endmodule

// File: tb/tb_stats_readout.sv
// tb_stats_readout: table-driven frame checks plus hand
// sequences for stall, recapture, mode clear, saturation, reset.
module tb_stats_readout;

  typedef logic [15:0] frame_t [12];

  typedef struct {
    string       name;
    int          nsamp;
    bit          samp_cap;
    bit          stall;
    bit          recap;
    logic [63:0] sum;
    logic [63:0] sq;
    frame_t      exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic        status = 1'b1;
  logic        capture = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] sum_in = '0;
  logic [63:0] sum_square_in = '0;
  logic        busy;
  logic        out_valid;
  logic        out_last;
  logic [15:0] out_data;

  int checks = 0;
  int failures = 0;

  frame_t rx;
  frame_t ef;
  vec_t   vt [4];

  stats_readout dut (
    .clk           (clk),
    .reset         (reset),
    .mode          (mode),
    .status        (status),
    .sum_in        (sum_in),
    .sum_square_in (sum_square_in),
    .capture       (capture),
    .busy          (busy),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic mk_frame(input logic [31:0] c, input logic [63:0] s,
                          input logic [63:0] q, output frame_t f);
    logic [15:0] cs;
    f[0] = 16'hA55A;
    f[1] = c[31:16];
    f[2] = c[15:0];
    for (int i = 0; i < 4; i++) begin
      f[3+i] = s[63-16*i -: 16];
      f[7+i] = q[63-16*i -: 16];
    end
    cs = '0;
    for (int i = 0; i < 11; i++) cs += f[i];
    f[11] = cs;
  endtask

  task automatic cmp(input string tag, input frame_t e);
    for (int i = 0; i < 12; i++)
      chk($sformatf("%s w%0d", tag, i), {48'h0, rx[i]}, {48'h0, e[i]});
  endtask

  // Called just after the capture edge; collects 12 transfers.
  task automatic get_frame(input string tag, input bit stall,
                           input bit recap);
    int          n = 0;
    int          cyc = 0;
    bit          held = 0;
    logic [15:0] pd = '0;
    logic        pl = 1'b0;
    logic        rdy;
    while (n < 12 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      capture = recap && (n == 3 || n == 11);
      rdy = !stall || (cyc % 4 == 1) || (cyc % 4 == 0);
      chk({tag, " valid"}, out_valid, 1);
      if (held) begin
        chk({tag, " hold data"}, out_data, pd);
        chk({tag, " hold last"}, out_last, pl);
      end
      out_ready = rdy;
      if (rdy) begin
        rx[n] = out_data;
        chk($sformatf("%s last w%0d", tag, n), out_last, (n == 11));
        n++;
      end
      held = !rdy;
      pd = out_data;
      pl = out_last;
    end
    if (n < 12) chk({tag, " timeout"}, n, 12);
  endtask

  initial begin
    vt[0] = '{name: "empty", nsamp: 0, samp_cap: 0, stall: 0, recap: 0,
              sum: 64'd0, sq: 64'd0,
              exp: '{16'hA55A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                     16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hA55A}};
    vt[1] = '{name: "s123", nsamp: 3, samp_cap: 1, stall: 0, recap: 0,
              sum: 64'd6, sq: 64'd14,
              exp: '{16'hA55A, 16'h0, 16'h3, 16'h0, 16'h0, 16'h0,
                     16'h6, 16'h0, 16'h0, 16'h0, 16'hE, 16'hA571}};
    vt[2] = '{name: "stall", nsamp: 2, samp_cap: 0, stall: 1, recap: 0,
              sum: 64'h0001_0002_0003_0004,
              sq: 64'h1000_2000_3000_4000,
              exp: '{16'hA55A, 16'h0, 16'h2, 16'h1, 16'h2, 16'h3,
                     16'h4, 16'h1000, 16'h2000, 16'h3000, 16'h4000,
                     16'h4566}};
    vt[3] = '{name: "recap", nsamp: 5, samp_cap: 0, stall: 0, recap: 1,
              sum: 64'hFFFF_FFFF_FFFF_FFFF,
              sq: 64'h8000_0000_0000_0001,
              exp: '{16'hA55A, 16'h0, 16'h5, 16'hFFFF, 16'hFFFF,
                     16'hFFFF, 16'hFFFF, 16'h8000, 16'h0, 16'h0,
                     16'h1, 16'h255C}};

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst valid", out_valid, 0);
    chk("rst last", out_last, 0);
    chk("rst data", out_data, 0);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      mode = 0; status = 1; capture = 0; out_ready = 0;
      @(negedge clk);
      mode = 1;
      sum_in = vt[v].sum;
      sum_square_in = vt[v].sq;
      repeat (vt[v].nsamp) begin
        status = 0;
        @(negedge clk);
      end
      status = ~vt[v].samp_cap;
      capture = 1;
      @(posedge clk);
      #1;
      status = 1;
      sum_in = ~vt[v].sum;
      sum_square_in = ~vt[v].sq;
      get_frame(vt[v].name, vt[v].stall, vt[v].recap);
      cmp(vt[v].name, vt[v].exp);
      @(negedge clk);
      chk({vt[v].name, " busy after"}, busy, 0);
      capture = 0;
      sum_in = vt[v].sum;
      sum_square_in = vt[v].sq;
      if (vt[v].recap) begin
        capture = 1;
        @(posedge clk);
        #1;
        chk("k13 busy", busy, 1);
        chk("k13 hdr", out_data, 16'hA55A);
        get_frame("k13", 0, 0);
        cmp("k13", vt[v].exp);
        @(negedge clk);
        capture = 0;
      end
    end

    // mode cleared mid-frame: frame keeps count, next frame shows 0
    @(negedge clk);
    mode = 0; status = 1; capture = 0;
    @(negedge clk);
    mode = 1; sum_in = 64'd7; sum_square_in = 64'd9;
    repeat (4) begin
      status = 0;
      @(negedge clk);
    end
    status = 1;
    capture = 1;
    @(posedge clk);
    #1;
    mode = 0;
    get_frame("modeclr", 0, 0);
    mk_frame(32'd4, 64'd7, 64'd9, ef);
    cmp("modeclr", ef);
    @(negedge clk);
    mode = 1;
    capture = 1;
    @(posedge clk);
    #1;
    get_frame("cnt0", 0, 0);
    mk_frame(32'd0, 64'd7, 64'd9, ef);
    cmp("cnt0", ef);

    // saturation near the top of the counter
    @(negedge clk);
    capture = 0; mode = 1; status = 1;
    force dut.u_cnt.cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.u_cnt.cnt_q;
    status = 0;
    @(negedge clk);
    @(negedge clk);
    status = 1;
    capture = 1;
    @(posedge clk);
    #1;
    get_frame("sat", 0, 0);
    mk_frame(32'hFFFF_FFFF, 64'd7, 64'd9, ef);
    cmp("sat", ef);

    // reset during word 5
    @(negedge clk);
    capture = 0;
    sum_in = 64'h1111_2222_3333_4444;
    sum_square_in = 64'h5555_6666_7777_8888;
    capture = 1;
    @(posedge clk);
    #1;
    repeat (5) begin
      @(negedge clk);
      capture = 0;
      out_ready = 1;
    end
    @(negedge clk);
    chk("mid w5", out_data, 16'h3333);
    reset = 1;
    #1;
    chk("arst busy", busy, 0);
    chk("arst valid", out_valid, 0);
    chk("arst last", out_last, 0);
    chk("arst data", out_data, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    capture = 1;
    @(posedge clk);
    #1;
    get_frame("postrst", 0, 0);
    mk_frame(32'd0, 64'h1111_2222_3333_4444,
             64'h5555_6666_7777_8888, ef);
    cmp("postrst", ef);
    @(negedge clk);
    chk("postrst busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
